// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the gate sweep checker.
// Bit k of a truth table is the expected gate output for input vector k.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [1:0] TT_NOT1  = 2'b01;

endpackage

// File: rtl/gate_sweep_checker_settle_counter.sv
// Loadable down-counter that paces how long each input vector is held.
// Terminal count is asserted while the count sits at zero.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_value,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives every input combination into a gate, samples its output after a settle
// time and tallies mismatches against an expected truth table.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int                N_IN   = 2,
    parameter int                SETTLE = 2,
    parameter logic [2**N_IN-1:0] TT    = TT_AND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] a_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid,
    output logic [1:0]      dbg_state
);

    localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(2**N_IN - 1);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_count;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_valid;

    logic w_tc;
    logic w_last;
    logic w_mismatch;
    logic w_load;
    logic w_run;

    assign w_run      = (r_state == RUN);
    assign w_last     = (r_vec == LAST_VEC);
    assign w_mismatch = (y_in != TT[r_vec]);
    // Reload on sweep launch and on every vector advance except the last one.
    assign w_load     = (!w_run && start) || (w_run && w_tc && !w_last);

    settle_counter #(.W(4)) u_settle (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_run),
        .i_value (SETTLE_LD),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state      <= RUN;
                        r_vec        <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_fail_vec   <= '0;
                        r_fail_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_tc) begin
                        if (w_mismatch) begin
                            r_err_count <= r_err_count + (N_IN+1)'(1);
                            if (!r_fail_valid) begin
                                r_fail_vec   <= r_vec;
                                r_fail_valid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            // The final vector's sample lands in the same edge.
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_vec   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a 2-input instance against a selectable
// gate model and a 3-input instance against AND/NAND.
module tb_gate_sweep_checker;
    import gate_check_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // 2-input instance
    logic       start2;
    logic [1:0] a2;
    logic       y2;
    logic       busy2, done2, pass2, fv2;
    logic [2:0] err2;
    logic [1:0] fvec2;
    logic [1:0] st2;
    int         mode2;  // 0 = AND gate, 1 = stuck at 0, 2 = stuck at 1

    // 3-input instance
    logic       start3;
    logic [2:0] a3;
    logic       y3;
    logic       busy3, done3, pass3, fv3;
    logic [3:0] err3;
    logic [2:0] fvec3;
    logic [1:0] st3;
    logic       nand3;

    assign y2 = (mode2 == 0) ? (a2[0] & a2[1]) : (mode2 == 2);
    assign y3 = nand3 ? ~(&a3) : (&a3);

    gate_sweep_checker #(.N_IN(2), .SETTLE(2), .TT(TT_AND2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_out(a2), .y_in(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_vec(fvec2), .fail_valid(fv2), .dbg_state(st2)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(3), .TT(8'h80)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_out(a3), .y_in(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_vec(fvec3), .fail_valid(fv3), .dbg_state(st3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the 2-input instance and follow the sweep to DONE.
    // Returns busy cycle count, a_out sequence errors and err_count at busy cycles 1 and 2.
    task automatic sweep2(input int start_at, output int cyc, output int seq_err,
                          output logic [2:0] err_c1, output logic [2:0] err_c2);
        cyc = 0;
        seq_err = 0;
        err_c1 = 'x;
        err_c2 = 'x;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        chk("start_done_low", {31'd0, done2}, 32'd0);
        while (busy2 && cyc < 200) begin
            if (a2 !== 2'(cyc / 2)) seq_err++;
            if (done2 !== 1'b0) seq_err++;
            if (cyc == 1) err_c1 = err2;
            if (cyc == 2) err_c2 = err2;
            start2 = (cyc == start_at);
            cyc++;
            @(negedge clk);
        end
        start2 = 1'b0;
    endtask

    task automatic sweep3(output int cyc);
        cyc = 0;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        while (busy3 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic chk_results2(input string tag, input logic [2:0] e_err,
                                input logic [1:0] e_fvec, input logic e_fv, input logic e_pass);
        chk({tag, "_done"}, {31'd0, done2}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy2}, 32'd0);
        chk({tag, "_aout"}, {30'd0, a2}, 32'd0);
        chk({tag, "_err"}, {29'd0, err2}, {29'd0, e_err});
        chk({tag, "_fv"}, {31'd0, fv2}, {31'd0, e_fv});
        chk({tag, "_pass"}, {31'd0, pass2}, {31'd0, e_pass});
        if (e_fv) chk({tag, "_fvec"}, {30'd0, fvec2}, {30'd0, e_fvec});
    endtask

    int         cyc;
    int         seq_err;
    logic [2:0] c1, c2;

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        mode2  = 0;
        nand3  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs2", {busy2, done2, pass2, fv2, err2, fvec2, a2}, 32'd0);
        chk("rst_outputs3", {busy3, done3, pass3, fv3, err3, fvec3, a3}, 32'd0);
        chk("rst_state", {30'd0, st2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // good AND gate
        sweep2(-1, cyc, seq_err, c1, c2);
        chk("and_busy_cycles", cyc, 32'd8);
        chk("and_aout_seq", seq_err, 32'd0);
        chk_results2("and", 3'd0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("and_done_held", {31'd0, done2}, 32'd1);

        // output stuck at 0: only vector 11 fails
        mode2 = 1;
        sweep2(-1, cyc, seq_err, c1, c2);
        chk("st0_busy_cycles", cyc, 32'd8);
        chk_results2("st0", 3'd1, 2'b11, 1'b1, 1'b0);

        // output stuck at 1: vectors 00,01,10 fail; first error visible one cycle after sample
        mode2 = 2;
        sweep2(-1, cyc, seq_err, c1, c2);
        chk("st1_err_before", {29'd0, c1}, 32'd0);
        chk("st1_err_after", {29'd0, c2}, 32'd1);
        chk_results2("st1", 3'd3, 2'b00, 1'b1, 1'b0);

        // start during RUN is ignored
        mode2 = 0;
        sweep2(3, cyc, seq_err, c1, c2);
        chk("ign_busy_cycles", cyc, 32'd8);
        chk("ign_aout_seq", seq_err, 32'd0);
        chk_results2("ign", 3'd0, 2'd0, 1'b0, 1'b1);

        // asynchronous reset mid-sweep while a_out = 10
        mode2 = 2;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_aout", {30'd0, a2}, 32'd2);
        chk("mid_err", {29'd0, err2}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {busy2, done2, pass2, fv2, err2, fvec2, a2}, 32'd0);
        @(negedge clk) rst = 1'b0;
        mode2 = 0;
        sweep2(-1, cyc, seq_err, c1, c2);
        chk("post_rst_err_c1", {29'd0, c1}, 32'd0);
        chk("post_rst_busy_cycles", cyc, 32'd8);
        chk("post_rst_aout_seq", seq_err, 32'd0);
        chk_results2("post_rst", 3'd0, 2'd0, 1'b0, 1'b1);

        // 3-input AND, then the gate replaced by a NAND
        sweep3(cyc);
        chk("and3_busy_cycles", cyc, 32'd24);
        chk("and3_done", {31'd0, done3}, 32'd1);
        chk("and3_pass", {31'd0, pass3}, 32'd1);
        chk("and3_err", {28'd0, err3}, 32'd0);
        nand3 = 1'b1;
        sweep3(cyc);
        chk("nand3_busy_cycles", cyc, 32'd24);
        chk("nand3_err", {28'd0, err3}, 32'd8);
        chk("nand3_fvec", {29'd0, fvec3}, 32'd0);
        chk("nand3_fv", {31'd0, fv3}, 32'd1);
        chk("nand3_pass", {31'd0, pass3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
